// File: rtl/adrv9001_rx_packetizer.sv
// ADRV9001 rx packetizer: frames the free-running rx I/Q sample stream into
// fixed-length AXI-Stream packets through a small first-word-fall-through
// FIFO, and keeps drop and packet counters for software status.
module adrv9001_rx_packetizer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                 s_axis_aclk,
    input  logic                 s_axis_rstn,
    input  logic [31:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 enable,
    input  logic [LEN_WIDTH-1:0] packet_len,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 active,
    output logic                 overflow,
    output logic [31:0]          overflow_cnt,
    output logic [31:0]          packet_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        CAPTURE
    } state_t;

    state_t               state;
    logic                 enable_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] word_cnt;

    logic [32:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;

    logic                 full;
    logic                 empty;
    logic                 wr_en;
    logic                 rd_en;
    logic                 drop;
    logic                 tlast_bit;
    logic                 enable_rise;
    logic [LEN_WIDTH-1:0] len_sel;

    // Full is taken from the pre-read occupancy, so a same-cycle read never
    // rescues a write into a full FIFO.
    assign full        = (count == (AW+1)'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign rd_en       = !empty && m_axis_tready;
    assign wr_en       = (state == CAPTURE) && s_axis_tvalid && !full;
    assign drop        = (state == CAPTURE) && s_axis_tvalid && full;
    assign tlast_bit   = (word_cnt == (len_q - LEN_WIDTH'(1)));
    assign enable_rise = enable && !enable_q;
    assign len_sel     = (packet_len == '0) ? LEN_WIDTH'(1) : packet_len;

    assign active        = (state == CAPTURE);
    assign m_axis_tvalid = !empty;
    // Gate with empty so outputs read as zero out of reset (storage is not reset).
    assign m_axis_tdata  = empty ? '0 : mem[rd_ptr][31:0];
    assign m_axis_tlast  = empty ? 1'b0 : mem[rd_ptr][32];

    // Capture FSM: arming, packet framing, drop accounting.
    always_ff @(posedge s_axis_aclk or negedge s_axis_rstn) begin
        if (!s_axis_rstn) begin
            state        <= IDLE;
            enable_q     <= 1'b0;
            len_q        <= LEN_WIDTH'(1);
            word_cnt     <= '0;
            overflow     <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            enable_q <= enable;
            case (state)
                IDLE: begin
                    if (enable_rise) begin
                        len_q    <= len_sel;
                        overflow <= 1'b0;
                        word_cnt <= '0;
                        state    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (wr_en) begin
                        if (tlast_bit) begin
                            word_cnt <= '0;
                            if (enable) begin
                                len_q <= len_sel;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            word_cnt <= word_cnt + LEN_WIDTH'(1);
                        end
                    end else if (drop) begin
                        overflow <= 1'b1;
                        if (overflow_cnt != '1) begin
                            overflow_cnt <= overflow_cnt + 32'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers, occupancy and delivered-packet counter.
    always_ff @(posedge s_axis_aclk or negedge s_axis_rstn) begin
        if (!s_axis_rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            packet_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
                if (mem[rd_ptr][32]) begin
                    packet_cnt <= packet_cnt + 32'd1;
                end
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge s_axis_aclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {tlast_bit, s_axis_tdata};
        end
    end

endmodule

// File: tb/tb_adrv9001_rx_packetizer.sv
// Self-checking bench for adrv9001_rx_packetizer: a behavioural model pushes
// expected {tlast, tdata} words into a queue as samples are driven; words are
// popped and compared as the DUT hands them out.
module tb_adrv9001_rx_packetizer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   s_tdata;
    logic          s_tvalid;
    logic          en;
    logic [LW-1:0] plen;
    logic [31:0]   m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          act;
    logic          ovf;
    logic [31:0]   ovf_cnt;
    logic [31:0]   pkt_cnt;

    always #5 clk = ~clk;

    adrv9001_rx_packetizer #(
        .FIFO_DEPTH(DEPTH),
        .LEN_WIDTH (LW)
    ) dut (
        .s_axis_aclk  (clk),
        .s_axis_rstn  (rst_n),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .enable       (en),
        .packet_len   (plen),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .active       (act),
        .overflow     (ovf),
        .overflow_cnt (ovf_cnt),
        .packet_cnt   (pkt_cnt)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Model state
    logic [32:0]   exp_q [$];
    logic          m_cap;
    logic          m_en_q;
    int unsigned   m_len;
    int unsigned   m_wc;
    logic          m_ovf;
    longint        m_ovf_cnt;
    int unsigned   m_pkt;
    int unsigned   words_out;

    task automatic chk(input string tag, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act_v, exp_v, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_cap     = 1'b0;
        m_en_q    = 1'b0;
        m_len     = 1;
        m_wc      = 0;
        m_ovf     = 1'b0;
        m_ovf_cnt = 0;
        m_pkt     = 0;
        words_out = 0;
    endtask

    // One clock cycle: drive inputs at the falling edge, compare current
    // outputs against the model, then advance the model across the next rising edge.
    task automatic step(input logic e, input logic tv, input logic [31:0] td, input logic rdy);
        logic        full;
        logic [32:0] w;
        logic        tl;
        @(negedge clk);
        en       = e;
        s_tvalid = tv;
        s_tdata  = td;
        m_tready = rdy;
        #1;
        chk("tvalid", {31'd0, m_tvalid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            w = exp_q[0];
            chk("tdata", m_tdata, w[31:0]);
            chk("tlast", {31'd0, m_tlast}, {31'd0, w[32]});
        end
        chk("active", {31'd0, act}, {31'd0, m_cap});
        chk("overflow", {31'd0, ovf}, {31'd0, m_ovf});
        chk("overflow_cnt", ovf_cnt, m_ovf_cnt[31:0]);
        chk("packet_cnt", pkt_cnt, m_pkt);
        if (m_tvalid && rdy) words_out++;

        full = (exp_q.size() == DEPTH);
        if (exp_q.size() != 0 && rdy) begin
            w = exp_q.pop_front();
            if (w[32]) m_pkt++;
        end
        if (!m_cap) begin
            if (e && !m_en_q) begin
                m_len = (plen == 0) ? 1 : int'(plen);
                m_ovf = 1'b0;
                m_wc  = 0;
                m_cap = 1'b1;
            end
        end else if (tv) begin
            if (!full) begin
                tl = (m_wc == m_len - 1);
                exp_q.push_back({tl, td});
                if (tl) begin
                    m_wc = 0;
                    if (e) m_len = (plen == 0) ? 1 : int'(plen);
                    else   m_cap = 1'b0;
                end else begin
                    m_wc++;
                end
            end else begin
                m_ovf = 1'b1;
                if (m_ovf_cnt < 64'hFFFF_FFFF) m_ovf_cnt++;
            end
        end
        m_en_q = e;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Let the FIFO empty with no new samples; an expired bound is a failure.
    task automatic drain(input logic e, input logic toggle);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step(e, 1'b0, 32'd0, toggle ? logic'(n % 2 == 0) : 1'b1);
            n++;
        end
        settle();
        chk("drain_done", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        en       = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        #1;
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
        chk("rst_active", {31'd0, act}, 32'd0);
        chk("rst_overflow", {31'd0, ovf}, 32'd0);
        chk("rst_overflow_cnt", ovf_cnt, 32'd0);
        chk("rst_packet_cnt", pkt_cnt, 32'd0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        plen     = LW'(4);
        model_clear();

        // Framing: len 4, 10 samples
        do_reset();
        plen = LW'(4);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 1; i <= 10; i++) step(1'b1, 1'b1, 32'(i), 1'b1);
        drain(1'b1, 1'b0);
        chk("frm_packet_cnt", pkt_cnt, 32'd2);
        chk("frm_active", {31'd0, act}, 32'd1);

        // Overflow and backpressure: len 64, 20 samples into a 16-deep FIFO
        do_reset();
        plen = LW'(64);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 1; i <= 20; i++) step(1'b1, 1'b1, 32'(i), 1'b0);
        settle();
        chk("ovf_cnt_4", ovf_cnt, 32'd4);
        chk("ovf_flag", {31'd0, ovf}, 32'd1);
        chk("ovf_tvalid", {31'd0, m_tvalid}, 32'd1);
        chk("ovf_head", m_tdata, 32'd1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 1; i <= 48; i++) step(1'b1, 1'b1, 32'(100 + i), 1'b1);
        drain(1'b1, 1'b0);
        chk("ovf_packet_cnt", pkt_cnt, 32'd1);
        chk("ovf_cnt_final", ovf_cnt, 32'd4);

        // enable falls mid-packet
        do_reset();
        plen = LW'(8);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 32'(i), 1'b1);
        for (int i = 4; i <= 13; i++) step(1'b0, 1'b1, 32'(i), 1'b1);
        drain(1'b0, 1'b0);
        chk("endrop_words", words_out, 32'd8);
        chk("endrop_packet_cnt", pkt_cnt, 32'd1);
        chk("endrop_active", {31'd0, act}, 32'd0);

        // packet_len = 0 behaves as 1
        do_reset();
        plen = LW'(0);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 32'(i), 1'b1);
        drain(1'b1, 1'b0);
        chk("len0_packet_cnt", pkt_cnt, 32'd5);

        // packet_len change mid-packet applies to the next packet
        do_reset();
        plen = LW'(4);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 1; i <= 2; i++) step(1'b1, 1'b1, 32'(i), 1'b1);
        plen = LW'(6);
        for (int i = 3; i <= 10; i++) step(1'b1, 1'b1, 32'(i), 1'b1);
        drain(1'b1, 1'b0);
        chk("lenchg_packet_cnt", pkt_cnt, 32'd2);

        // tready toggling over two packets of 5
        do_reset();
        plen = LW'(5);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 32'(200 + i), logic'(i % 2 == 0));
        drain(1'b1, 1'b1);
        chk("hold_packet_cnt", pkt_cnt, 32'd2);
        chk("hold_words", words_out, 32'd10);

        // Reset mid-packet with words buffered
        do_reset();
        plen = LW'(8);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 32'(300 + i), 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'(400 + i), 1'b1);
        settle();
        chk("postrst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("postrst_active", {31'd0, act}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
